pc_update_unit: RTL and testbench
=================================

// Module: pc_update_unit
// PURPOSE
//  Parametrised program-counter unit for the multicycle MIPS core. It generalises
//  the PC source mux into a sequenced block. It owns the PC and EPC registers,
//  selects among NSRC next-PC sources with conditional/unconditional writes, and
//  runs the exception entry sequence: save EPC, read the handler byte from memory,
//  then jump. Sits between the control FSM, ALU/shift paths and memory.
// PARAMETERS
//  WIDTH      32      PC/data width in bits
//  NSRC       5       number of next-PC sources on src_flat (>=2)
//  SELW       3       width of sel; must satisfy 2**SELW >= NSRC
//  RESET_PC   0       PC value after reset
//  VEC_BASE   253     memory byte address of the handler byte for cause 1
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            asynchronous, active-low reset
//  src_flat   in   NSRC*WIDTH   source i occupies bits [i*WIDTH +: WIDTH]
//  sel        in   SELW         source index
//  pc_write   in   1            unconditional PC load
//  pc_wcond   in   1            conditional PC load (branch)
//  cond_true  in   1            branch condition from ALU
//  eret       in   1            return from exception: PC <= EPC
//  exc_req    in   2            cause: 0 none, 1 bad opcode, 2 overflow, 3 div0
//  mem_byte   in   8            byte returned by memory one cycle after vec_rd
//  pc_out     out  WIDTH        current PC
//  epc_out    out  WIDTH        saved exception PC
//  cause_out  out  2            latched cause
//  vec_addr   out  WIDTH        handler byte address = VEC_BASE + cause - 1
//  vec_rd     out  1            memory read strobe for vec_addr
//  exc_busy   out  1            high while the exception sequence runs
//  sel_err    out  1            one-cycle pulse: load attempted with sel >= NSRC
// BEHAVIOUR
//  Reset: pc_out=RESET_PC, epc_out=0, cause_out=0, vec_addr=0, vec_rd=0,
//   exc_busy=0, sel_err=0, FSM=IDLE. Reset mid-sequence aborts to IDLE at once.
//  load = pc_write | (pc_wcond & cond_true). In IDLE, a load takes effect on the
//   next edge: pc_out <= src[sel]. Latency is 1 cycle.
//  If sel >= NSRC: PC holds and sel_err is high for exactly the following cycle.
//  Priority in IDLE: exc_req!=0 > eret > load. Lower-priority requests in the
//   same cycle are dropped, not queued.
//  eret in IDLE: pc_out <= epc_out on the next edge.
//  FSM states: IDLE -> SAVE -> FETCH -> LOAD -> IDLE.
//   IDLE: when exc_req!=0, go to SAVE.
//   SAVE (1 cycle): epc_out <= pc_out - 4 (mod 2**WIDTH); cause_out <= exc_req.
//   FETCH (1 cycle): vec_rd=1; vec_addr = VEC_BASE + cause_out - 1.
//   LOAD (1 cycle): pc_out <= {{WIDTH-8{1'b0}}, mem_byte}; vec_rd=0.
//  exc_busy is high in SAVE, FETCH and LOAD. All pc_write, pc_wcond, eret and
//   exc_req inputs are ignored while busy.
//  Exception entry to the new PC takes 3 cycles after exc_req is sampled.
//  pc_out - 4 at pc_out=0 wraps to 2**WIDTH-4.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined: a load or eret whose target has nonzero bits
//   [1:0] does not update PC. It forces an exception entry with cause 1 on the
//   next edge, and epc_out saves the current pc_out - 4.
//  PC_ALIGN_CHECK_EN undefined: targets are written unmodified and no check is
//   done. The handler jump in LOAD is never checked.
// TESTING
//  1 reset low mid-FETCH -> all outputs return to reset values immediately;
//    pc_out=0.
//  2 sel=2, src2=0x0000_0040, pc_write=1 -> pc_out=0x40 on the next edge;
//    sel=6 (NSRC=5) -> PC holds and sel_err pulses for 1 cycle.
//  3 pc_wcond=1, cond_true=0 -> PC unchanged; cond_true=1 -> PC <= src[sel].
//  4 pc_out=0x100, exc_req=2, mem_byte=0x7C -> SAVE: epc=0xFC, cause=2;
//    FETCH: vec_rd=1, vec_addr=254; LOAD: pc=0x7C; exc_busy high for 3 cycles.
//  5 exc_req=1 and eret and pc_write in the same cycle -> exception wins;
//    pc_write during busy is ignored; later eret -> pc_out=epc_out.
//  6 PC_ALIGN_CHECK_EN defined, load target 0x42 -> PC not loaded and cause 1
//    sequence entered. Undefined -> pc_out=0x42.

Source files
------------

// File: rtl/pc_update_unit.sv
// pc_update_unit: program-counter block for the multicycle MIPS core.
// Owns PC and EPC, muxes NSRC next-PC sources under conditional/unconditional
// load, and sequences exception entry (save EPC, fetch handler byte, jump).
// Optional feature macro: PC_ALIGN_CHECK_EN -- misaligned load/eret targets
// are refused and turned into a cause-1 exception entry.
// Handshake note: there is no valid/ready pair here; requests (load, eret,
// exc_req) are single-cycle strobes sampled only while the FSM is IDLE, and
// anything presented while exc_busy is high is dropped.
module pc_update_unit #(
    parameter int WIDTH    = 32,
    parameter int NSRC     = 5,
    parameter int SELW     = 3,
    parameter int RESET_PC = 0,
    parameter int VEC_BASE = 253
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NSRC*WIDTH-1:0] src_flat,
    input  logic [SELW-1:0]       sel,
    input  logic                  pc_write,
    input  logic                  pc_wcond,
    input  logic                  cond_true,
    input  logic                  eret,
    input  logic [1:0]            exc_req,
    input  logic [7:0]            mem_byte,
    output logic [WIDTH-1:0]      pc_out,
    output logic [WIDTH-1:0]      epc_out,
    output logic [1:0]            cause_out,
    output logic [WIDTH-1:0]      vec_addr,
    output logic                  vec_rd,
    output logic                  exc_busy,
    output logic                  sel_err,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SAVE  = 2'd1,
        FETCH = 2'd2,
        LOAD  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] src_sel;
    logic             sel_ok;
    logic             load;
    logic             start_exc;
    logic [1:0]       new_cause;
    logic             do_eret;
    logic             do_load;
    logic             bad_sel;

    assign load      = pc_write | (pc_wcond & cond_true);
    assign exc_busy  = (state != IDLE);
    assign vec_rd    = (state == FETCH);
    assign fsm_state = state;

    // Handler byte address is only driven while the read strobe is up.
    always_comb begin
        vec_addr = '0;
        if (state == FETCH)
            vec_addr = WIDTH'(VEC_BASE) + WIDTH'(cause_out) - WIDTH'(1);
    end

    // Source mux; sel_ok flags whether sel names an existing source.
    always_comb begin
        src_sel = '0;
        sel_ok  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SELW'(i)) begin
                src_sel = src_flat[i*WIDTH +: WIDTH];
                sel_ok  = 1'b1;
            end
        end
    end

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and request arbitration: exception > eret > load.
    always_comb begin
        state_next = state;
        start_exc  = 1'b0;
        new_cause  = exc_req;
        do_eret    = 1'b0;
        do_load    = 1'b0;
        bad_sel    = 1'b0;
        case (state)
            IDLE: begin
                if (exc_req != 2'd0) begin
                    state_next = SAVE;
                    start_exc  = 1'b1;
                end else if (eret) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (epc_out[1:0] != 2'b00) begin
                        state_next = SAVE;
                        start_exc  = 1'b1;
                        new_cause  = 2'd1;
                    end else begin
                        do_eret = 1'b1;
                    end
`else
                    do_eret = 1'b1;
`endif
                end else if (load) begin
                    if (!sel_ok) begin
                        bad_sel = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                    end else if (src_sel[1:0] != 2'b00) begin
                        state_next = SAVE;
                        start_exc  = 1'b1;
                        new_cause  = 2'd1;
`endif
                    end else begin
                        do_load = 1'b1;
                    end
                end
            end
            SAVE:    state_next = FETCH;
            FETCH:   state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // PC, EPC, cause and sel_err datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out    <= WIDTH'(RESET_PC);
            epc_out   <= '0;
            cause_out <= 2'd0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= bad_sel;
            if (start_exc) begin
                epc_out   <= pc_out - WIDTH'(4);
                cause_out <= new_cause;
            end
            if (state == LOAD)
                pc_out <= {{(WIDTH-8){1'b0}}, mem_byte};
            else if (do_eret)
                pc_out <= epc_out;
            else if (do_load)
                pc_out <= src_sel;
        end
    end

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed testbench for pc_update_unit (WIDTH=32, NSRC=5, SELW=3).
module tb_pc_update_unit;

    localparam int WIDTH = 32;
    localparam int NSRC  = 5;
    localparam int SELW  = 3;

    logic                  clk;
    logic                  reset;
    logic [NSRC*WIDTH-1:0] src_flat;
    logic [SELW-1:0]       sel;
    logic                  pc_write;
    logic                  pc_wcond;
    logic                  cond_true;
    logic                  eret;
    logic [1:0]            exc_req;
    logic [7:0]            mem_byte;
    logic [WIDTH-1:0]      pc_out;
    logic [WIDTH-1:0]      epc_out;
    logic [1:0]            cause_out;
    logic [WIDTH-1:0]      vec_addr;
    logic                  vec_rd;
    logic                  exc_busy;
    logic                  sel_err;
    logic [1:0]            fsm_state;

    int checks;
    int failures;

    pc_update_unit #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .RESET_PC(0), .VEC_BASE(253)) dut (
        .clk(clk), .reset(reset), .src_flat(src_flat), .sel(sel),
        .pc_write(pc_write), .pc_wcond(pc_wcond), .cond_true(cond_true),
        .eret(eret), .exc_req(exc_req), .mem_byte(mem_byte),
        .pc_out(pc_out), .epc_out(epc_out), .cause_out(cause_out),
        .vec_addr(vec_addr), .vec_rd(vec_rd), .exc_busy(exc_busy),
        .sel_err(sel_err), .fsm_state(fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge, then settle 1 time unit for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [WIDTH-1:0] val);
        src_flat[idx*WIDTH +: WIDTH] = val;
    endtask

    task automatic idle_inputs();
        pc_write = 0; pc_wcond = 0; cond_true = 0; eret = 0; exc_req = 2'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        sel = '0; src_flat = '0; mem_byte = 8'h00;
        step(); step();
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
        checks++; if (epc_out !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=%h", epc_out, 32'h0); end
        checks++; if ({cause_out, vec_rd, exc_busy, sel_err} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=%b", {cause_out, vec_rd, exc_busy, sel_err}, 5'b0); end
        checks++; if (vec_addr !== 32'h0) begin failures++; $display("FAIL reset_vec_addr got=%h exp=%h", vec_addr, 32'h0); end
        checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, 0); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_load();
        set_src(2, 32'h0000_0040);
        sel = 3'd2; pc_write = 1;
        step();
        pc_write = 0;
        checks++; if (pc_out !== 32'h40) begin failures++; $display("FAIL load_pc got=%h exp=%h", pc_out, 32'h40); end
        checks++; if (sel_err !== 1'b0) begin failures++; $display("FAIL load_no_sel_err got=%b exp=%b", sel_err, 1'b0); end
        sel = 3'd6; pc_write = 1;
        step();
        pc_write = 0;
        checks++; if (pc_out !== 32'h40) begin failures++; $display("FAIL bad_sel_pc_hold got=%h exp=%h", pc_out, 32'h40); end
        checks++; if (sel_err !== 1'b1) begin failures++; $display("FAIL bad_sel_pulse got=%b exp=%b", sel_err, 1'b1); end
        step();
        checks++; if (sel_err !== 1'b0) begin failures++; $display("FAIL bad_sel_pulse_end got=%b exp=%b", sel_err, 1'b0); end
    endtask

    task automatic test_wcond();
        set_src(1, 32'h0000_0080);
        sel = 3'd1; pc_wcond = 1; cond_true = 0;
        step();
        checks++; if (pc_out !== 32'h40) begin failures++; $display("FAIL wcond_false got=%h exp=%h", pc_out, 32'h40); end
        cond_true = 1;
        step();
        pc_wcond = 0; cond_true = 0;
        checks++; if (pc_out !== 32'h80) begin failures++; $display("FAIL wcond_true got=%h exp=%h", pc_out, 32'h80); end
    endtask

    task automatic test_exception();
        set_src(3, 32'h0000_0100);
        sel = 3'd3; pc_write = 1;
        step();
        pc_write = 0;
        checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL exc_setup_pc got=%h exp=%h", pc_out, 32'h100); end
        exc_req = 2'd2; mem_byte = 8'h7C;
        step();
        exc_req = 2'd0;
        checks++; if (epc_out !== 32'hFC) begin failures++; $display("FAIL save_epc got=%h exp=%h", epc_out, 32'hFC); end
        checks++; if (cause_out !== 2'd2) begin failures++; $display("FAIL save_cause got=%0d exp=%0d", cause_out, 2); end
        checks++; if ({exc_busy, vec_rd} !== 2'b10) begin failures++; $display("FAIL save_busy_rd got=%b exp=%b", {exc_busy, vec_rd}, 2'b10); end
        checks++; if (fsm_state !== 2'd1) begin failures++; $display("FAIL save_state got=%0d exp=%0d", fsm_state, 1); end
        step();
        checks++; if ({exc_busy, vec_rd} !== 2'b11) begin failures++; $display("FAIL fetch_busy_rd got=%b exp=%b", {exc_busy, vec_rd}, 2'b11); end
        checks++; if (vec_addr !== 32'd254) begin failures++; $display("FAIL fetch_vec_addr got=%0d exp=%0d", vec_addr, 254); end
        step();
        checks++; if ({exc_busy, vec_rd} !== 2'b10) begin failures++; $display("FAIL load_busy_rd got=%b exp=%b", {exc_busy, vec_rd}, 2'b10); end
        checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL load_pc_not_yet got=%h exp=%h", pc_out, 32'h100); end
        step();
        checks++; if (pc_out !== 32'h7C) begin failures++; $display("FAIL handler_pc got=%h exp=%h", pc_out, 32'h7C); end
        checks++; if (exc_busy !== 1'b0) begin failures++; $display("FAIL exc_done_busy got=%b exp=%b", exc_busy, 1'b0); end
    endtask

    task automatic test_priority();
        set_src(0, 32'h0000_0200);
        sel = 3'd0; mem_byte = 8'h30;
        exc_req = 2'd1; eret = 1; pc_write = 1;
        step();
        exc_req = 2'd0; eret = 0;
        checks++; if (cause_out !== 2'd1) begin failures++; $display("FAIL prio_cause got=%0d exp=%0d", cause_out, 1); end
        checks++; if (epc_out !== 32'h78) begin failures++; $display("FAIL prio_epc got=%h exp=%h", epc_out, 32'h78); end
        checks++; if (pc_out !== 32'h7C) begin failures++; $display("FAIL prio_pc_hold got=%h exp=%h", pc_out, 32'h7C); end
        eret = 1; exc_req = 2'd3;
        step();
        step();
        eret = 0; exc_req = 2'd0;
        checks++; if (pc_out !== 32'h7C) begin failures++; $display("FAIL busy_ignore_pc got=%h exp=%h", pc_out, 32'h7C); end
        checks++; if (cause_out !== 2'd1) begin failures++; $display("FAIL busy_ignore_cause got=%0d exp=%0d", cause_out, 1); end
        step();
        pc_write = 0;
        checks++; if (pc_out !== 32'h30) begin failures++; $display("FAIL prio_handler_pc got=%h exp=%h", pc_out, 32'h30); end
        eret = 1;
        step();
        eret = 0;
        checks++; if (pc_out !== 32'h78) begin failures++; $display("FAIL eret_pc got=%h exp=%h", pc_out, 32'h78); end
    endtask

    task automatic test_wrap();
        set_src(4, 32'h0);
        sel = 3'd4; pc_write = 1;
        step();
        pc_write = 0;
        exc_req = 2'd3; mem_byte = 8'h11;
        step();
        exc_req = 2'd0;
        checks++; if (epc_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_epc got=%h exp=%h", epc_out, 32'hFFFF_FFFC); end
        checks++; if (cause_out !== 2'd3) begin failures++; $display("FAIL wrap_cause got=%0d exp=%0d", cause_out, 3); end
        step();
        checks++; if (vec_addr !== 32'd255) begin failures++; $display("FAIL wrap_vec_addr got=%0d exp=%0d", vec_addr, 255); end
        step(); step();
        checks++; if (pc_out !== 32'h11) begin failures++; $display("FAIL wrap_handler_pc got=%h exp=%h", pc_out, 32'h11); end
    endtask

    task automatic test_align();
        set_src(1, 32'h0000_0042);
        sel = 3'd1; pc_write = 1;
        step();
        pc_write = 0;
`ifdef PC_ALIGN_CHECK_EN
        checks++; if (pc_out !== 32'h11) begin failures++; $display("FAIL align_pc_hold got=%h exp=%h", pc_out, 32'h11); end
        checks++; if ({exc_busy, cause_out} !== 3'b101) begin failures++; $display("FAIL align_exc got=%b exp=%b", {exc_busy, cause_out}, 3'b101); end
        checks++; if (epc_out !== 32'h0D) begin failures++; $display("FAIL align_epc got=%h exp=%h", epc_out, 32'h0D); end
        step(); step(); step();
`else
        checks++; if (pc_out !== 32'h42) begin failures++; $display("FAIL align_off_pc got=%h exp=%h", pc_out, 32'h42); end
        checks++; if (exc_busy !== 1'b0) begin failures++; $display("FAIL align_off_busy got=%b exp=%b", exc_busy, 1'b0); end
`endif
    endtask

    task automatic test_reset_mid_fetch();
        exc_req = 2'd1; mem_byte = 8'h55;
        step();
        exc_req = 2'd0;
        step();
        checks++; if (vec_rd !== 1'b1) begin failures++; $display("FAIL midfetch_vec_rd got=%b exp=%b", vec_rd, 1'b1); end
        #2 reset = 1'b0;
        #1;
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL midfetch_pc got=%h exp=%h", pc_out, 32'h0); end
        checks++; if (epc_out !== 32'h0) begin failures++; $display("FAIL midfetch_epc got=%h exp=%h", epc_out, 32'h0); end
        checks++; if ({cause_out, vec_rd, exc_busy, sel_err} !== 5'b0) begin failures++; $display("FAIL midfetch_flags got=%b exp=%b", {cause_out, vec_rd, exc_busy, sel_err}, 5'b0); end
        checks++; if (vec_addr !== 32'h0) begin failures++; $display("FAIL midfetch_vec_addr got=%h exp=%h", vec_addr, 32'h0); end
        step();
        reset = 1'b1;
        step();
        checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL midfetch_state got=%0d exp=%0d", fsm_state, 0); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_load();
        test_wcond();
        test_exception();
        test_priority();
        test_wrap();
        test_align();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
